// File: rtl/md_pkg.sv
// md_pkg: shared op encodings and latency-counter width
// for the HI/LO multiply/divide unit.
package md_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MTLO  = 4'd1,
    MD_MTHI  = 4'd2,
    MD_DIVU  = 4'd3,
    MD_DIV   = 4'd4,
    MD_MULTU = 4'd5,
    MD_MULT  = 4'd6,
    MD_MFLO  = 4'd7,
    MD_MFHI  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

endpackage

// File: rtl/md_lat_ctr.sv
// md_lat_ctr: loadable down-counter that stops at zero
// and flags it; paces multi-cycle md operations.
module md_lat_ctr
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load wins over decrement; saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS-style HI/LO multiply/divide unit.
// Define MD_MADD_EN to add the madd/maddu/msub/msubu ops.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  logic [WIDTH-1:0] hi_q, lo_q, a_q, b_q;
  logic [3:0]       op_q;
  logic             busy_q;
  logic             cnt_zero;

  logic accept, dec_long, dec_div;
  logic dec_mthi, dec_mtlo;

  // decode the issued op; undefined codes fall to no-op
  always_comb begin
    dec_long = 1'b0;
    dec_div  = 1'b0;
    dec_mthi = 1'b0;
    dec_mtlo = 1'b0;
    case (op)
      MD_MTLO:  dec_mtlo = 1'b1;
      MD_MTHI:  dec_mthi = 1'b1;
      MD_DIVU,
      MD_DIV: begin
        dec_long = 1'b1;
        dec_div  = 1'b1;
      end
      MD_MULTU,
      MD_MULT:  dec_long = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD,
      MD_MADDU,
      MD_MSUB,
      MD_MSUBU: dec_long = 1'b1;
`endif
      default: ;
    endcase
  end

  assign accept = start && !busy_q;

  md_lat_ctr u_ctr (
    .clk    (clk),
    .rst_n  (reset_n),
    .load_i (accept && dec_long),
    .val_i  (dec_div ? DIV_LD : MUL_LD),
    .dec_i  (busy_q),
    .zero_o (cnt_zero)
  );

  logic [W2-1:0] uprod, sprod, prod;
  logic [WIDTH-1:0] mag_a, mag_b, dvs;
  logic [WIDTH-1:0] uq, ur, q, r;
  logic sa, sb, sgn_mul;
  logic [W2-1:0] divres, res;

  assign uprod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign sprod = {{WIDTH{a_q[WIDTH-1]}}, a_q}
               * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign sgn_mul = (op_q == MD_MULT) || (op_q == MD_MADD)
                || (op_q == MD_MSUB);
  assign prod = sgn_mul ? sprod : uprod;

  // divide on magnitudes, then restore signs
  always_comb begin
    sa    = (op_q == MD_DIV) && a_q[WIDTH-1];
    sb    = (op_q == MD_DIV) && b_q[WIDTH-1];
    mag_a = sa ? -a_q : a_q;
    mag_b = sb ? -b_q : b_q;
    dvs   = (b_q == '0) ? WIDTH'(1) : mag_b;
    uq    = mag_a / dvs;
    ur    = mag_a % dvs;
    q     = (sa ^ sb) ? -uq : uq;
    r     = sa ? -ur : ur;
    if (b_q == '0) divres = {a_q, {WIDTH{1'b1}}};
    else           divres = {r, q};
  end

  // result written to {HI,LO} when the op completes
  always_comb begin
    res = {hi_q, lo_q};
    case (op_q)
      MD_DIVU,
      MD_DIV:   res = divres;
      MD_MULTU,
      MD_MULT:  res = prod;
`ifdef MD_MADD_EN
      MD_MADD,
      MD_MADDU: res = {hi_q, lo_q} + prod;
      MD_MSUB,
      MD_MSUBU: res = {hi_q, lo_q} - prod;
`endif
      default: ;
    endcase
  end

  // architectural state, operand latch and busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      if (accept && dec_mthi) hi_q <= a;
      if (accept && dec_mtlo) lo_q <= a;
      if (accept && dec_long) begin
        busy_q <= 1'b1;
        op_q   <= op;
        a_q    <= a;
        b_q    <= b;
      end else if (busy_q && cnt_zero) begin
        busy_q <= 1'b0;
        hi_q   <= res[W2-1:WIDTH];
        lo_q   <= res[WIDTH-1:0];
      end
    end
  end

  // move-from read port
  always_comb begin
    rdata = '0;
    if (op == MD_MFHI)      rdata = hi_q;
    else if (op == MD_MFLO) rdata = lo_q;
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector table plus hand-written
// sequences for stall, read-during-busy and reset abort.
module tb_md_unit;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MTLO  = 4'd1;
  localparam logic [3:0] MTHI  = 4'd2;
  localparam logic [3:0] DIVU  = 4'd3;
  localparam logic [3:0] DIV   = 4'd4;
  localparam logic [3:0] MULTU = 4'd5;
  localparam logic [3:0] MULT  = 4'd6;
  localparam logic [3:0] MFLO  = 4'd7;
  localparam logic [3:0] MFHI  = 4'd8;
  localparam logic [3:0] MADDU = 4'd10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] rdata, hi, lo;

  md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .rdata   (rdata),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o,
                       input logic [31:0] aa,
                       input logic [31:0] bb,
                       output int n);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = aa;
    b = bb;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = NONE;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{"mult_m1x2",  MULT,  32'hFFFFFFFF, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{"multu_m1x2", MULTU, 32'hFFFFFFFF, 32'd2,
                 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{"div_m7_2",   DIV,   32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{"div_5_0",    DIV,   32'd5, 32'd0,
                 32'd5, 32'hFFFFFFFF, 10};
    vecs[4]  = '{"div_ovf",    DIV,   32'h80000000, 32'hFFFFFFFF,
                 32'd0, 32'h80000000, 10};
    vecs[5]  = '{"divu_7_2",   DIVU,  32'd7, 32'd2,
                 32'd1, 32'd3, 10};
    vecs[6]  = '{"divu_big",   DIVU,  32'hFFFFFFFF, 32'h10,
                 32'hF, 32'h0FFFFFFF, 10};
    vecs[7]  = '{"div_7_m2",   DIV,   32'd7, 32'hFFFFFFFE,
                 32'd1, 32'hFFFFFFFD, 10};
    vecs[8]  = '{"divu_9_0",   DIVU,  32'd9, 32'd0,
                 32'd9, 32'hFFFFFFFF, 10};
    vecs[9]  = '{"mult_3xm4",  MULT,  32'd3, 32'hFFFFFFFC,
                 32'hFFFFFFFF, 32'hFFFFFFF4, 5};
    vecs[10] = '{"multu_2p32", MULTU, 32'h10000, 32'h10000,
                 32'd1, 32'd0, 5};
    vecs[11] = '{"div_m16_0",  DIV,   32'hFFFFFFF0, 32'd0,
                 32'hFFFFFFF0, 32'hFFFFFFFF, 10};
    vecs[12] = '{"mthi",       MTHI,  32'h1234, 32'd0,
                 32'h1234, 32'hFFFFFFFF, 0};
    vecs[13] = '{"mtlo",       MTLO,  32'h0000ABCD, 32'd0,
                 32'h1234, 32'h0000ABCD, 0};
    vecs[14] = '{"op_none",    NONE,  32'd5, 32'd5,
                 32'h1234, 32'h0000ABCD, 0};
    vecs[15] = '{"op_undef",   4'd15, 32'd5, 32'd5,
                 32'h1234, 32'h0000ABCD, 0};
    vecs[16] = '{"mtlo_ones",  MTLO,  32'hFFFFFFFF, 32'd0,
                 32'h1234, 32'hFFFFFFFF, 0};
    vecs[17] = '{"mthi_zero",  MTHI,  32'd0, 32'd0,
                 32'd0, 32'hFFFFFFFF, 0};

    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk({vecs[i].name, "_lat"}, 32'(n), 32'(vecs[i].lat));
      chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
    end

    issue(MADDU, 32'd1, 32'd1, n);
`ifdef MD_MADD_EN
    chk("maddu_lat", 32'(n), 32'd5);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
`else
    chk("maddu_lat", 32'(n), 32'd0);
    chk("maddu_hi", hi, 32'd0);
    chk("maddu_lo", lo, 32'hFFFFFFFF);
`endif

    issue(MTHI, 32'h1234, 32'd0, n);
    @(negedge clk);
    op = MFHI;
    #1;
    chk("mfhi_next", rdata, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);

    issue(MTHI, 32'h55, 32'd0, n);
    issue(MTLO, 32'h66, 32'd0, n);
    @(negedge clk);
    start = 1'b1;
    op = MULT;
    a = 32'd2;
    b = 32'd3;
    @(posedge clk);
    #1;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 1) begin
        a = 32'd7;
        b = 32'd7;
      end else if (n == 2) begin
        start = 1'b0;
        op = MFHI;
        #1;
        chk("mfhi_busy", rdata, 32'h55);
        op = MFLO;
        #1;
        chk("mflo_busy", rdata, 32'h66);
      end
      @(posedge clk);
      #1;
    end
    chk("stall_lat", 32'(n), 32'd5);
    chk("stall_hi", hi, 32'd0);
    chk("stall_lo", lo, 32'd6);
    op = MFLO;
    #1;
    chk("mflo_after", rdata, 32'd6);
    op = NONE;

    @(negedge clk);
    start = 1'b1;
    op = DIV;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = NONE;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_hi", hi, 32'd0);
    chk("post_lo", lo, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);

    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1;
    op = MTLO;
    a = 32'hABCD;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = NONE;
    chk("first_op", lo, 32'hABCD);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
